filter_spad_reader: RTL and testbench
=====================================

FILTER_SPAD_READER -- requirements
Module: filter_spad_reader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 224, meaning filter scratchpad depth in words.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning weight width.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(MEM_DEPTH), meaning scratchpad address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a read sequence; sampled in IDLE only.
REQ-007 SHALL have port filt_size  input  4  weights per filter row (S), 1..15.
REQ-008 SHALL have port num_chan  input  5  channels per pass (q), 1..31.
REQ-009 SHALL have port num_filt  input  5  filters per pass (p), 1..31.
REQ-010 SHALL have port num_pass  input  8  repetitions of the full weight block (output pixels), 1..255.
REQ-011 SHALL have port spad_wcount  input  ADDR_WIDTH  scratchpad write pointer (words written so far).
REQ-012 SHALL have port spad_r_en  output  1  scratchpad read enable.
REQ-013 SHALL have port spad_r_addr  output  ADDR_WIDTH  scratchpad read address.
REQ-014 SHALL have port spad_dout  input  DATA_WIDTH  scratchpad read data, valid on the rising edge after spad_r_en.
REQ-015 SHALL have port out_data  output  DATA_WIDTH  weight to MAC.
REQ-016 SHALL have port out_valid  output  1  out_data valid.
REQ-017 SHALL have port out_ready  input  1  MAC accepts out_data.
REQ-018 SHALL have port out_first / out_last  output  1 each  flag first / last weight of a pass, qualified by out_valid.
REQ-019 SHALL have port busy  output  1  high from accepted start until done.
REQ-020 SHALL have port done  output  1  one-cycle pulse after last weight of last pass is accepted.
REQ-021 SHALL have port cfg_err  output  1  one-cycle pulse on rejected start.

Function
REQ-022 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start with valid config; RUN->DRAIN when last read of last pass issued; DRAIN->IDLE when output buffer empty and last beat accepted (done pulses that cycle).
REQ-023 SHALL reject start when any of filt_size, num_chan, num_filt, num_pass is zero or S*q*p > MEM_DEPTH: pulse cfg_err, remain IDLE.
REQ-024 SHALL latch all config inputs on accepted start; later changes ignored until IDLE.
REQ-025 SHALL generate addresses by nested counters f (inner, 0..p-1), c (0..q-1), s (outer, 0..S-1); address = s*q*p + c*p + f, realised as a linear counter 0..S*q*p-1 (no multiplier in address path).
REQ-026 SHALL reset the address to 0 at the end of each pass; pass counter increments 0..num_pass-1.
REQ-027 SHALL assert spad_r_en only when in RUN, spad_r_addr < spad_wcount, and (buffered words + in-flight reads) < 2.
REQ-028 SHALL hold spad_r_addr stable while stalled; spad_r_en low during stall.
REQ-029 SHALL capture spad_dout one cycle after each spad_r_en into a 2-entry FIFO output buffer; out_valid = buffer non-empty.
REQ-030 SHALL transfer a beat when out_valid && out_ready; out_data and flags stable while out_valid && !out_ready.
REQ-031 SHALL sustain one beat per cycle when out_ready held high and data available.
REQ-032 SHALL carry out_first/out_last with each buffered word (address 0 / address S*q*p-1).
REQ-033 SHALL ignore start while busy.
REQ-034 SHALL produce exactly S*q*p*num_pass beats per run, in address order, no duplicates or drops.

Reset
REQ-035 SHALL on reset (any time, including mid-run) asynchronously clear state to IDLE, counters to 0, buffer empty, and drive spad_r_en, spad_r_addr, out_data, out_valid, out_first, out_last, busy, done, cfg_err to 0.
REQ-036 SHALL on reset release issue no read before a new accepted start.

Verification
REQ-037 S=3,q=1,p=1,pass=2, spad preloaded w0..w2, out_ready=1 -> out_data w0,w1,w2,w0,w1,w2 back-to-back; out_first on beats 1,4; out_last on 3,6; done one cycle after beat 6.
REQ-038 S=2,q=2,p=2, spad_wcount rising 1 word per 3 cycles -> reads never exceed wcount-1; 8 beats in address order 0..7.
REQ-039 out_ready toggled randomly -> no more than 2 outstanding words; no drop/duplicate; data stable while stalled.
REQ-040 start with num_chan=0, and separately S=15,q=31,p=31 -> cfg_err pulse, busy stays 0, no spad_r_en.
REQ-041 reset asserted mid-RUN with buffer full -> all outputs 0 immediately; next start restarts at address 0.
REQ-042 start pulsed again while busy -> ignored; beat count unchanged.

Source files
------------

// File: rtl/filter_spad_reader.sv
// Streams filter weights from the filter scratchpad to the MAC array, replaying the
// S*q*p weight block num_pass times through a 2-entry output buffer with ready/valid.
module filter_spad_reader #(
   parameter int MEM_DEPTH  = 224,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0]            filt_size,
   input  logic [4:0]            num_chan,
   input  logic [4:0]            num_filt,
   input  logic [7:0]            num_pass,
   input  logic [ADDR_WIDTH-1:0] spad_wcount,
   output logic                  spad_r_en,
   output logic [ADDR_WIDTH-1:0] spad_r_addr,
   input  logic [DATA_WIDTH-1:0] spad_dout,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_first,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [ADDR_WIDTH-1:0] last_addr_r;
   logic [7:0]            pass_r;
   logic [7:0]            num_pass_r;
   logic                  infl_r;
   logic                  infl_first_r;
   logic                  infl_last_r;
   logic [1:0]            count_r;
   logic [DATA_WIDTH-1:0] data0_r;
   logic [DATA_WIDTH-1:0] data1_r;
   logic                  first0_r;
   logic                  first1_r;
   logic                  last0_r;
   logic                  last1_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  cfg_err_r;

   logic [13:0]           total_s;
   logic                  cfg_ok_s;
   logic                  accept_s;
   logic                  reject_s;
   logic                  pop_s;
   logic                  push_s;
   logic [1:0]            occ_s;
   logic                  issue_s;
   logic                  addr_last_s;
   logic                  pass_last_s;
   logic                  last_issue_s;
   logic                  final_beat_s;

   // Config check, read-issue throttle and handshake decode
   always_comb begin
      total_s  = {10'd0, filt_size} * {9'd0, num_chan} * {9'd0, num_filt};
      cfg_ok_s = (filt_size != 4'd0) && (num_chan != 5'd0) && (num_filt != 5'd0) &&
                 (num_pass != 8'd0) && ({18'd0, total_s} <= 32'(MEM_DEPTH));
      accept_s = (state_r == IDLE) && start && cfg_ok_s;
      reject_s = (state_r == IDLE) && start && !cfg_ok_s;
      pop_s    = (count_r != 2'd0) && out_ready;
      push_s   = infl_r;
      // Occupancy as it stands after this cycle's handshake, so a full-rate stream keeps flowing.
      occ_s    = count_r + {1'b0, infl_r} - {1'b0, pop_s};
      issue_s  = (state_r == RUN) && (addr_r < spad_wcount) && (occ_s < 2'd2);
      addr_last_s  = (addr_r == last_addr_r);
      pass_last_s  = (pass_r == (num_pass_r - 8'd1));
      last_issue_s = issue_s && addr_last_s && pass_last_s;
      final_beat_s = (state_r == DRAIN) && !infl_r && (count_r == 2'd1) && pop_s;
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_s = RUN;
            else          state_s = IDLE;
         end
         RUN: begin
            if (last_issue_s) state_s = DRAIN;
            else              state_s = RUN;
         end
         DRAIN: begin
            if (final_beat_s) state_s = IDLE;
            else              state_s = DRAIN;
         end
         default: state_s = IDLE;
      endcase
   end

   // State register, latched configuration and linear address / pass counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         addr_r      <= {ADDR_WIDTH{1'b0}};
         last_addr_r <= {ADDR_WIDTH{1'b0}};
         pass_r      <= 8'd0;
         num_pass_r  <= 8'd0;
      end else begin
         state_r <= state_s;
         if (accept_s) begin
            addr_r      <= {ADDR_WIDTH{1'b0}};
            last_addr_r <= ADDR_WIDTH'(total_s - 14'd1);
            pass_r      <= 8'd0;
            num_pass_r  <= num_pass;
         end else if (issue_s) begin
            if (addr_last_s) begin
               addr_r <= {ADDR_WIDTH{1'b0}};
               pass_r <= pass_r + 8'd1;
            end else begin
               addr_r <= addr_r + ADDR_WIDTH'(1);
            end
         end
      end
   end

   // Tag of the read whose data returns next cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         infl_r       <= 1'b0;
         infl_first_r <= 1'b0;
         infl_last_r  <= 1'b0;
      end else begin
         infl_r       <= issue_s;
         infl_first_r <= (addr_r == {ADDR_WIDTH{1'b0}});
         infl_last_r  <= addr_last_s;
      end
   end

   // Two-entry output buffer; entry 0 is always the head presented to the MAC
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r  <= 2'd0;
         data0_r  <= {DATA_WIDTH{1'b0}};
         data1_r  <= {DATA_WIDTH{1'b0}};
         first0_r <= 1'b0;
         first1_r <= 1'b0;
         last0_r  <= 1'b0;
         last1_r  <= 1'b0;
      end else begin
         count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
         case ({push_s, pop_s})
            2'b10: begin
               if (count_r == 2'd0) begin
                  data0_r  <= spad_dout;
                  first0_r <= infl_first_r;
                  last0_r  <= infl_last_r;
               end else begin
                  data1_r  <= spad_dout;
                  first1_r <= infl_first_r;
                  last1_r  <= infl_last_r;
               end
            end
            2'b01: begin
               data0_r  <= data1_r;
               first0_r <= first1_r;
               last0_r  <= last1_r;
            end
            2'b11: begin
               if (count_r == 2'd1) begin
                  data0_r  <= spad_dout;
                  first0_r <= infl_first_r;
                  last0_r  <= infl_last_r;
               end else begin
                  data0_r  <= data1_r;
                  first0_r <= first1_r;
                  last0_r  <= last1_r;
                  data1_r  <= spad_dout;
                  first1_r <= infl_first_r;
                  last1_r  <= infl_last_r;
               end
            end
            default: begin
               count_r <= count_r;
            end
         endcase
      end
   end

   // Registered status: busy level, done and cfg_err pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         cfg_err_r <= 1'b0;
      end else begin
         busy_r    <= (state_s != IDLE);
         done_r    <= final_beat_s;
         cfg_err_r <= reject_s;
      end
   end

   assign spad_r_en   = issue_s;
   assign spad_r_addr = addr_r;
   assign out_data    = data0_r;
   assign out_valid   = (count_r != 2'd0);
   assign out_first   = first0_r;
   assign out_last    = last0_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_filter_spad_reader.sv
// Self-checking bench for filter_spad_reader: a synchronous scratchpad model, a beat-queue
// reference built from the run configuration, and a per-cycle monitor on the falling edge.
module tb_filter_spad_reader;
   localparam int MEM_DEPTH = 224;
   localparam int DW = 16;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [3:0]    filt_size = 4'd0;
   logic [4:0]    num_chan = 5'd0;
   logic [4:0]    num_filt = 5'd0;
   logic [7:0]    num_pass = 8'd0;
   logic [AW-1:0] spad_wcount = 8'd224;
   logic          spad_r_en;
   logic [AW-1:0] spad_r_addr;
   logic [DW-1:0] spad_dout;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_first;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          cfg_err;

   always #5 clk = ~clk;

   filter_spad_reader #(.MEM_DEPTH(MEM_DEPTH), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .start(start), .filt_size(filt_size),
      .num_chan(num_chan), .num_filt(num_filt), .num_pass(num_pass),
      .spad_wcount(spad_wcount), .spad_r_en(spad_r_en), .spad_r_addr(spad_r_addr),
      .spad_dout(spad_dout), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
      .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   // Scratchpad: data appears the cycle after the read enable
   logic [DW-1:0] mem [0:255];
   always @(posedge clk) if (spad_r_en) spad_dout <= mem[spad_r_addr];

   typedef struct packed {
      logic [DW-1:0] d;
      logic          f;
      logic          l;
   } beat_t;

   beat_t         exp_q[$];
   beat_t         mon_e;
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            total = 1;
   int            exp_beats = 0;
   int            exp_addr = 0;
   int            reads = 0;
   int            beats = 0;
   int            done_seen = 0;
   int            done_cyc = 0;
   int            last_beat_cyc = 0;
   bit            expect_reads = 1'b0;
   bit            stall_prev = 1'b0;
   logic [17:0]   prev_out = 18'd0;
   bit            log_en = 1'b0;
   logic [DW-1:0] log_d[$];
   bit            log_f[$];
   bit            log_l[$];
   int            log_c[$];

   logic [DW-1:0] t1_data [6] = '{16'h5A00, 16'h5A01, 16'h5A02, 16'h5A00, 16'h5A01, 16'h5A02};
   logic [5:0]    t1_first = 6'b001001;
   logic [5:0]    t1_last  = 6'b100100;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle monitor against the reference stream
   always @(negedge clk) begin
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid_held", 32'(out_valid), 32'd1);
            chk("stall_data_held", 32'({out_data, out_first, out_last}), 32'(prev_out));
         end
         if (!expect_reads) chk("unexpected_read", 32'(spad_r_en), 32'd0);
         else if (spad_r_en) begin
            chk("read_below_wcount", 32'(spad_r_addr < spad_wcount), 32'd1);
            chk("read_addr_order", 32'(spad_r_addr), exp_addr);
            exp_addr = (exp_addr + 1) % total;
            reads++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
            else begin
               mon_e = exp_q.pop_front();
               chk("beat_data_flags", 32'({out_data, out_first, out_last}),
                   32'({mon_e.d, mon_e.f, mon_e.l}));
            end
            beats++;
            last_beat_cyc = cyc;
            if (log_en) begin
               log_d.push_back(out_data);
               log_f.push_back(out_first);
               log_l.push_back(out_last);
               log_c.push_back(cyc);
            end
         end
         if (expect_reads) chk("outstanding_le_2", 32'((reads - beats) <= 2), 32'd1);
         if (done) begin
            done_seen++;
            done_cyc = cyc;
            chk("done_after_last_beat", cyc, last_beat_cyc + 1);
            chk("done_model_drained", exp_q.size(), 32'd0);
         end
         stall_prev = out_valid && !out_ready;
         prev_out   = {out_data, out_first, out_last};
      end
   end

   task automatic start_run(input int s, input int q, input int p, input int np);
      beat_t b;
      total = s * q * p;
      exp_beats = total * np;
      exp_q.delete();
      exp_addr = 0; reads = 0; beats = 0; done_seen = 0;
      for (int k = 0; k < np; k++)
         for (int a = 0; a < total; a++) begin
            b.d = mem[8'(a)];
            b.f = (a == 0);
            b.l = (a == total - 1);
            exp_q.push_back(b);
         end
      expect_reads = 1'b1;
      filt_size = 4'(s); num_chan = 5'(q); num_filt = 5'(p); num_pass = 8'(np);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_until_done(input int budget, input bit rnd, input bit ramp, input int poke);
      int n = 0;
      while (done_seen == 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         if (ramp && (n % 3 == 0) && (32'(spad_wcount) < total)) spad_wcount = spad_wcount + 8'd1;
         start = (n == poke);
         if (n == poke) begin num_pass = 8'd1; filt_size = 4'd1; end
      end
      start = 1'b0;
      chk("done_within_budget", done_seen, 32'd1);
      chk("beat_count", beats, exp_beats);
      chk("model_drained", exp_q.size(), 32'd0);
      expect_reads = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("done_single_pulse", done_seen, 32'd1);
      chk("busy_low_after_done", 32'(busy), 32'd0);
   endtask

   task automatic try_bad(input string nm, input int s, input int q, input int p, input int np);
      filt_size = 4'(s); num_chan = 5'(q); num_filt = 5'(p); num_pass = 8'(np);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({nm, "_cfg_err"}, 32'(cfg_err), 32'd1);
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk({nm, "_cfg_err_pulse"}, 32'(cfg_err), 32'd0);
      chk({nm, "_busy_later"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h5A00 + 16'(i);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_r_en", 32'(spad_r_en), 32'd0);
      chk("rst_r_addr", 32'(spad_r_addr), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_flags", 32'({out_first, out_last}), 32'd0);
      chk("rst_status", 32'({busy, done, cfg_err}), 32'd0);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_busy", 32'(busy), 32'd0);

      // Two passes of a 3-word block at full rate
      log_en = 1'b1;
      start_run(3, 1, 1, 2);
      run_until_done(100, 1'b0, 1'b0, 0);
      log_en = 1'b0;
      chk("t1_beats_logged", log_d.size(), 32'd6);
      if (log_d.size() == 6) begin
         for (int k = 0; k < 6; k++) begin
            chk("t1_data", 32'(log_d[k]), 32'(t1_data[k]));
            chk("t1_first", 32'(log_f[k]), 32'(t1_first[k]));
            chk("t1_last", 32'(log_l[k]), 32'(t1_last[k]));
            chk("t1_back_to_back", log_c[k] - log_c[0], k);
         end
         chk("t1_done_cycle", done_cyc - log_c[5], 32'd1);
      end

      // Scratchpad fill racing the reader
      spad_wcount = 8'd0;
      start_run(2, 2, 2, 1);
      run_until_done(200, 1'b0, 1'b1, 0);
      spad_wcount = 8'd224;

      // Random backpressure, with a start pulse while busy
      start_run(3, 2, 2, 3);
      run_until_done(600, 1'b1, 1'b0, 5);

      // Largest block that fits the scratchpad
      start_run(14, 16, 1, 1);
      run_until_done(600, 1'b0, 1'b0, 0);

      try_bad("zero_chan", 3, 0, 1, 1);
      try_bad("too_big", 15, 31, 31, 1);
      try_bad("just_over", 15, 15, 1, 1);

      // Reset in the middle of a run with the buffer full
      out_ready = 1'b0;
      start_run(4, 2, 2, 1);
      repeat (6) @(posedge clk);
      #1;
      chk("full_valid", 32'(out_valid), 32'd1);
      chk("full_head", 32'(out_data), 32'h5A00);
      #2;
      reset = 1'b1;
      expect_reads = 1'b0;
      #1;
      chk("midrst_r_en", 32'(spad_r_en), 32'd0);
      chk("midrst_r_addr", 32'(spad_r_addr), 32'd0);
      chk("midrst_out", 32'({out_data, out_valid, out_first, out_last}), 32'd0);
      chk("midrst_status", 32'({busy, done, cfg_err}), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      out_ready = 1'b1;
      start_run(4, 2, 2, 1);
      run_until_done(200, 1'b0, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
